systolic_operand_feeder: RTL

Operand-side driver for the N×N output-stationary systolic MAC array. It holds one A and one B operand matrix, written element by element, and on `start` streams them into the array's left edge (`a_out`, one lane per row) and top edge (`b_out`, one lane per column) with the diagonal skew the array needs. It also issues the array's clear pulse and signals when the array's C outputs are final. It sits between the host/DMA register interface and the array.

---
 rtl/systolic_operand_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - A/B operand banks and skewed edge streaming for an NxN systolic MAC array.
// Outputs are registered from the current state, so they trail the FSM by one cycle.
module systolic_operand_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [$clog2(N)-1:0]  wr_col,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic                  arr_rst,
  output logic [DATA_W-1:0]     a_out [N],
  output logic [DATA_W-1:0]     b_out [N],
  output logic                  busy,
  output logic                  done,
  output logic                  c_valid
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARST   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              arr_rst_q, arr_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              c_valid_q, c_valid_d;
  logic [DATA_W-1:0] a_out_q [N];
  logic [DATA_W-1:0] a_out_d [N];
  logic [DATA_W-1:0] b_out_q [N];
  logic [DATA_W-1:0] b_out_d [N];
  logic [DATA_W-1:0] a_bank_q [N][N];
  logic [DATA_W-1:0] a_bank_d [N][N];
  logic [DATA_W-1:0] b_bank_q [N][N];
  logic [DATA_W-1:0] b_bank_d [N][N];

  logic wr_ok;
  assign wr_ok = wr_en && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    a_bank_d = a_bank_q;
    b_bank_d = b_bank_q;
    if (wr_ok) begin
      if (wr_sel) b_bank_d[wr_row][wr_col] = wr_data;
      else        a_bank_d[wr_row][wr_col] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARST;
          cnt_d   = '0;
        end
      end
      S_ARST: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // N+1 zero cycles let the last products reach the far corner PE
        if (cnt_q == CW'(N)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = start ? S_ARST : S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    int t;
    int k;
    t         = int'(cnt_q);
    k         = 0;
    arr_rst_d = (state_q == S_ARST);
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_DONE);
    c_valid_d = c_valid_q;
    if (state_q == S_DONE)      c_valid_d = 1'b1;
    else if (state_q == S_ARST) c_valid_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_out_d[i] = '0;
      b_out_d[i] = '0;
      k = t - i;
      // Lane i enters i cycles late, giving the diagonal wavefront
      if (state_q == S_STREAM && k >= 0 && k < N) begin
        a_out_d[i] = a_bank_q[i][k[RW-1:0]];
        b_out_d[i] = b_bank_q[k[RW-1:0]][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_bank_q <= a_bank_d;
    b_bank_q <= b_bank_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      arr_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_out_q[i] <= '0;
        b_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arr_rst_q <= arr_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_valid_q <= c_valid_d;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
    end
  end

  assign arr_rst = arr_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign c_valid = c_valid_q;
  assign a_out   = a_out_q;
  assign b_out   = b_out_q;

endmodule
